// File: rtl/snn_neuron_core.sv
// rtl/snn_neuron_core.sv - ternary-weight spiking neuron array, one timestep per start
// Optional membrane leak on non-firing neurons is built only when LEAK_EN is defined.
module snn_neuron_core #(
  parameter int N_NEU = 16,
  parameter int N_IN  = 16,
  parameter logic signed [7:0] THRESH = 8'sd64,
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 spk_sel,
  input  logic                 u_sel,
  input  logic [N_IN-1:0]      in_spk,
  input  logic [8*N_NEU-1:0]   u_in,
  input  logic [2*N_NEU-1:0]   w_in,
  output logic [IW-1:0]        in_idx,
  output logic [8*N_NEU-1:0]   u_out,
  output logic [N_NEU-1:0]     spk_out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIRE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_idx;
  logic [N_IN-1:0]       r_spk;
  logic [8*N_NEU-1:0]    r_prev;
  logic signed [7:0]     r_acc [N_NEU];
  logic [8*N_NEU-1:0]    r_u_out;
  logic [N_NEU-1:0]      r_spk_out;
  logic                  r_done;

  logic                  w_last;
  logic [N_IN-1:0]       w_fb_spk;
  logic signed [7:0]     w_acc_nxt [N_NEU];
  logic signed [7:0]     w_sum [N_NEU];
  logic [N_NEU-1:0]      w_fire;
  logic [8*N_NEU-1:0]    w_u_new;

  // Clamp a 9-bit sum of two sign-extended bytes back into signed 8 bits.
  function automatic logic [7:0] sat9(input logic [8:0] v);
    case (v[8:7])
      2'b01:   sat9 = 8'h7F;
      2'b10:   sat9 = 8'h80;
      default: sat9 = v[7:0];
    endcase
  endfunction

  function automatic logic [8:0] wdec(input logic [1:0] w);
    case (w)
      2'b01:   wdec = 9'h001;
      2'b11:   wdec = 9'h1FF;
      default: wdec = 9'h000;
    endcase
  endfunction

  // Feedback spikes are sized to the input vector when N_IN and N_NEU differ.
  generate
    if (N_IN <= N_NEU) begin : g_fb_trunc
      assign w_fb_spk = r_spk_out[N_IN-1:0];
    end else begin : g_fb_ext
      assign w_fb_spk = {{(N_IN-N_NEU){1'b0}}, r_spk_out};
    end
  endgenerate

  assign w_last  = (r_idx == IW'(N_IN-1));
  assign in_idx  = r_idx;
  assign u_out   = r_u_out;
  assign spk_out = r_spk_out;
  assign done    = r_done;
  assign busy    = (r_state != S_IDLE);

  always_comb begin
    w_fire  = '0;
    w_u_new = '0;
    for (int j = 0; j < N_NEU; j++) begin
      w_acc_nxt[j] = sat9({r_acc[j][7], r_acc[j]} + wdec(w_in[2*j +: 2]));
      w_sum[j]     = sat9({r_prev[8*j+7], r_prev[8*j +: 8]} + {r_acc[j][7], r_acc[j]});
      w_fire[j]    = (w_sum[j] >= THRESH);
`ifdef LEAK_EN
      w_u_new[8*j +: 8] = w_fire[j] ? 8'h00 : w_sum[j] - (w_sum[j] >>> 4);
`else
      w_u_new[8*j +: 8] = w_fire[j] ? 8'h00 : w_sum[j];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_ACCUM;
      S_ACCUM: if (w_last) w_next = S_FIRE;
      S_FIRE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx     <= '0;
      r_spk     <= '0;
      r_prev    <= '0;
      r_u_out   <= '0;
      r_spk_out <= '0;
      r_done    <= 1'b0;
      for (int j = 0; j < N_NEU; j++) r_acc[j] <= '0;
    end else begin
      r_done <= (r_state == S_FIRE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_spk  <= spk_sel ? w_fb_spk : in_spk;
            r_prev <= u_sel ? r_u_out : u_in;
            r_idx  <= '0;
            for (int j = 0; j < N_NEU; j++) r_acc[j] <= '0;
          end
        end
        S_ACCUM: begin
          if (r_spk[r_idx]) begin
            for (int j = 0; j < N_NEU; j++) r_acc[j] <= w_acc_nxt[j];
          end
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        S_FIRE: begin
          r_spk_out <= w_fire;
          r_u_out   <= w_u_new;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_neuron_core.sv
// tb/tb_snn_neuron_core.sv - randomized bench for snn_neuron_core against an arithmetic timestep model
module tb_snn_neuron_core;
  localparam int NN = 16;
  localparam int NI = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            spk_sel;
  logic            u_sel;
  logic [NI-1:0]   in_spk;
  logic [8*NN-1:0] u_in;
  logic [2*NN-1:0] w_in;
  logic [3:0]      in_idx;
  logic [8*NN-1:0] u_out;
  logic [NN-1:0]   spk_out;
  logic            busy;
  logic            done;

  logic [1:0]      wmem [NI][NN];
  int              u_vals [NN];
  int              exp_u [NN];
  logic [NN-1:0]   exp_spk;
  int              n_cmp = 0;
  int              n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    w_in = '0;
    for (int j = 0; j < NN; j++) w_in[2*j +: 2] = wmem[in_idx][j];
  end

  always_comb begin
    u_in = '0;
    for (int j = 0; j < NN; j++) u_in[8*j +: 8] = u_vals[j][7:0];
  end

  snn_neuron_core #(.N_NEU(NN), .N_IN(NI), .THRESH(8'sd64)) dut (
    .clk(clk), .reset(reset), .start(start), .spk_sel(spk_sel), .u_sel(u_sel),
    .in_spk(in_spk), .u_in(u_in), .w_in(w_in), .in_idx(in_idx),
    .u_out(u_out), .spk_out(spk_out), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int wval(input logic [1:0] w);
    if (w == 2'b01) return 1;
    if (w == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int u_at(input int j);
    logic signed [7:0] v;
    v = u_out[8*j +: 8];
    return int'(v);
  endfunction

  // One whole timestep from the rules: integrate spikes*weights, add to the old potential, fire or keep.
  task automatic model_step(input logic ss, input logic su);
    int            prev, acc, sum;
    logic [NN-1:0] nspk;
    int            nu [NN];
    for (int j = 0; j < NN; j++) begin
      prev = su ? exp_u[j] : u_vals[j];
      acc  = 0;
      for (int i = 0; i < NI; i++)
        if (ss ? exp_spk[i] : in_spk[i]) acc = sat8(acc + wval(wmem[i][j]));
      sum = sat8(prev + acc);
      if (sum >= 64) begin
        nspk[j] = 1'b1;
        nu[j]   = 0;
      end else begin
        nspk[j] = 1'b0;
`ifdef LEAK_EN
        nu[j]   = sum - (sum >>> 4);
`else
        nu[j]   = sum;
`endif
      end
    end
    exp_spk = nspk;
    for (int j = 0; j < NN; j++) exp_u[j] = nu[j];
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_spk"}, int'(spk_out), int'(exp_spk));
    for (int j = 0; j < NN; j++) check($sformatf("%s_u%0d", pfx, j), u_at(j), exp_u[j]);
  endtask

  task automatic set_all(input int u, input logic [1:0] w, input logic [NI-1:0] s);
    for (int j = 0; j < NN; j++) u_vals[j] = u;
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < NN; j++) wmem[i][j] = w;
    in_spk = s;
  endtask

  task automatic randomize_inputs();
    for (int j = 0; j < NN; j++) u_vals[j] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < NN; j++) wmem[i][j] = 2'($urandom);
    in_spk = NI'($urandom);
  endtask

  // Launch one timestep; inputs are scrambled after the start edge to prove they were latched.
  task automatic run_step(input string pfx, input logic ss, input logic su, input bit poke);
    int cyc;
    bit got;
    model_step(ss, su);
    @(negedge clk);
    spk_sel = ss;
    u_sel   = su;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    in_spk = NI'($urandom);
    for (int j = 0; j < NN; j++) u_vals[j] = int'($urandom_range(0, 255)) - 128;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke && cyc == 5) start = 1'b1;
      else if (poke && cyc == 6) start = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({pfx, "_latency"}, cyc, 17);
    check_outputs(pfx);
    @(posedge clk);
    #1;
    check({pfx, "_done_pulse"}, int'(done), 0);
    check({pfx, "_busy_after"}, int'(busy), 0);
    check({pfx, "_spk_hold"}, int'(spk_out), int'(exp_spk));
  endtask

  initial begin
    int  cyc, first, second;
    bit  seen;
    reset   = 1'b0;
    start   = 1'b0;
    spk_sel = 1'b0;
    u_sel   = 1'b0;
    set_all(0, 2'b00, '0);
    exp_spk = '0;
    for (int j = 0; j < NN; j++) exp_u[j] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_idx", int'(in_idx), 0);
    check("rst_spk", int'(spk_out), 0);
    check("rst_u_zero", int'(u_out == '0), 1);
    @(negedge clk);
    reset = 1'b1;

    set_all(0, 2'b01, 16'hFFFF);
    run_step("all_plus", 1'b0, 1'b0, 1'b0);
`ifdef LEAK_EN
    check("all_plus_u0_const", u_at(0), 15);
`else
    check("all_plus_u0_const", u_at(0), 16);
`endif

    set_all(50, 2'b01, 16'hFFFF);
    run_step("fire_all", 1'b0, 1'b0, 1'b0);
    check("fire_all_const", int'(spk_out), 16'hFFFF);

    set_all(-120, 2'b11, 16'hFFFF);
    run_step("neg_sat", 1'b0, 1'b0, 1'b0);
`ifdef LEAK_EN
    check("neg_sat_const", u_at(5), -120);
`else
    check("neg_sat_const", u_at(5), -128);
`endif

    set_all(0, 2'b00, 16'h0001);
    wmem[0][0] = 2'b01;
    wmem[0][1] = 2'b11;
    wmem[0][2] = 2'b10;
    wmem[1][0] = 2'b01;
    run_step("mixed", 1'b0, 1'b0, 1'b0);
    check("mixed_n0", u_at(0), 1);
`ifdef LEAK_EN
    check("mixed_n1", u_at(1), 0);
`else
    check("mixed_n1", u_at(1), -1);
`endif
    check("mixed_n2", u_at(2), 0);

    randomize_inputs();
    for (int j = 0; j < NN; j++) u_vals[j] = int'($urandom_range(40, 90));
    run_step("pre_fb", 1'b0, 1'b0, 1'b0);
    randomize_inputs();
    run_step("feedback", 1'b1, 1'b1, 1'b0);

    randomize_inputs();
    run_step("busy_start", 1'b0, 1'b0, 1'b1);

    randomize_inputs();
    model_step(1'b0, 1'b0);
    @(negedge clk);
    spk_sel = 1'b0;
    u_sel   = 1'b0;
    start   = 1'b1;
    cyc = 0;
    first = -1;
    second = -1;
    while (second < 0 && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        if (first < 0) begin
          first = cyc;
          check("b2b_gap_idle", int'(busy), 0);
        end else begin
          second = cyc;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_first", first, 18);
    check("b2b_second", second, 36);
    check_outputs("b2b");

    randomize_inputs();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_idx", int'(in_idx), 0);
    check("midrst_spk", int'(spk_out), 0);
    check("midrst_u_zero", int'(u_out == '0), 1);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("midrst_no_restart", int'(seen), 0);
    exp_spk = '0;
    for (int j = 0; j < NN; j++) exp_u[j] = 0;

`ifdef LEAK_EN
    set_all(32, 2'b00, '0);
    run_step("leak", 1'b0, 1'b0, 1'b0);
    check("leak_const", u_at(3), 30);
`endif

    for (int k = 0; k < 12; k++) begin
      randomize_inputs();
      run_step($sformatf("rnd%0d", k), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snn_neuron_core.md
SNN_NEURON_CORE -- requirements
Module: snn_neuron_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset as in the codebase.
REQ-002 The block SHALL provide parameter N_NEU, default 16: number of neurons/accumulators.
REQ-003 The block SHALL provide parameter N_IN, default 16: number of presynaptic spike lines.
REQ-004 The block SHALL provide parameter THRESH, default 64: signed 8-bit firing threshold.
REQ-005 The block SHALL provide port clk, input, 1: rising-edge clock.
REQ-006 The block SHALL provide port reset, input, 1: asynchronous reset, active low.
REQ-007 The block SHALL provide port start, input, 1: begin one timestep; sampled only in IDLE.
REQ-008 The block SHALL provide port spk_sel, input, 1: spike source, 0 = in_spk, 1 = internal spk_out feedback.
REQ-009 The block SHALL provide port u_sel, input, 1: previous-potential source, 0 = u_in, 1 = internal u_out feedback.
REQ-010 The block SHALL provide port in_spk, input, N_IN: external spike vector.
REQ-011 The block SHALL provide port u_in, input, 8*N_NEU: previous potentials; neuron j is at bits [8j+7:8j], signed.
REQ-012 The block SHALL provide port w_in, input, 2*N_NEU: weight row for the current in_idx; neuron j is at bits [2j+1:2j].
REQ-013 The block SHALL provide port in_idx, output, clog2(N_IN): weight-row address.
REQ-014 The block SHALL provide port u_out, output, 8*N_NEU: final potentials, signed.
REQ-015 The block SHALL provide port spk_out, output, N_NEU: output spikes.
REQ-016 The block SHALL provide port busy, output, 1: high outside IDLE.
REQ-017 The block SHALL provide port done, output, 1: one-cycle pulse when a timestep completes.

Function
REQ-018 The state machine SHALL have the states IDLE, ACCUM and FIRE, with transitions IDLE->ACCUM on start, ACCUM->FIRE after N_IN cycles, and FIRE->IDLE.
REQ-019 On the start edge, the block SHALL latch the spike vector selected by spk_sel and the previous potentials selected by u_sel, clear all accumulators, and set in_idx to 0.
REQ-020 In ACCUM, in_idx SHALL count from 0 to N_IN-1, one value per cycle, and w_in SHALL be sampled in the same cycle as the in_idx it corresponds to.
REQ-021 Weight decode SHALL be: 2'b01 = +1, 2'b11 = -1, and 2'b00 or 2'b10 = 0.
REQ-022 On each ACCUM cycle where the latched spike[in_idx] is 1, accumulator j SHALL add the decoded weight of neuron j; when the spike is 0, the accumulator SHALL hold.
REQ-023 Accumulators SHALL be 8-bit signed and saturate at +127 and -128, with no wrap-around.
REQ-024 In FIRE, the block SHALL compute sum_j = saturate8(prev_j + acc_j).
REQ-025 If sum_j >= THRESH, the block SHALL set spk_out[j] = 1 and u_out_j = 0; otherwise it SHALL set spk_out[j] = 0 and u_out_j = sum_j, subject to REQ-033.
REQ-026 spk_out, u_out and done SHALL update at the FIRE edge, N_IN+1 clock edges after the start edge, and SHALL hold until the next FIRE or reset.
REQ-027 start asserted while busy SHALL be ignored.
REQ-028 start held high continuously SHALL launch back-to-back timesteps, with one IDLE cycle between them.
REQ-029 With spk_sel=1 or u_sel=1, the latched values SHALL be the spk_out/u_out registered at the preceding FIRE.

Reset
REQ-030 While reset is low, state SHALL be IDLE and in_idx, the accumulators, the latched spikes and potentials, u_out, spk_out, busy and done SHALL all be 0.
REQ-031 Reset asserted mid-timestep SHALL abort it with no FIRE and no done pulse.
REQ-032 After reset deasserts, the block SHALL require a new start.

Configuration
REQ-033 With LEAK_EN defined, a non-firing neuron SHALL output u_out_j = sum_j - (sum_j >>> 4) (arithmetic shift); without LEAK_EN, u_out_j = sum_j and no leak logic SHALL be present.

Verification
REQ-034 The bench SHALL cover: reset low mid-ACCUM -> busy=0, done never pulses, u_out=0, spk_out=0.
REQ-035 The bench SHALL cover: u_in all 0, in_spk=16'hFFFF, every w_in row all 2'b01, start -> done 17 cycles later, u_out_j = 16, spk_out = 0.
REQ-036 The bench SHALL cover: u_in_j = 50, same stimulus as REQ-035 -> sum = 66 >= 64, spk_out all 1, u_out all 0.
REQ-037 The bench SHALL cover: u_in_j = -120, all weights 2'b11, all spikes 1 -> saturates, u_out_j = -128.
REQ-038 The bench SHALL cover: mixed weights with in_spk=16'h0001, w row 0 neuron 0 = 2'b01, neuron 1 = 2'b11, neuron 2 = 2'b10 -> acc = +1, -1, 0.
REQ-039 The bench SHALL cover: a second timestep with spk_sel=1 and u_sel=1 -> uses the prior spk_out and u_out.
REQ-040 With LEAK_EN defined, the bench SHALL check: sum 32, no fire -> u_out 30.
